// File: rtl/simple_dp_ram_sclk.sv
// rtl/simple_dp_ram_sclk.sv - single-clock simple dual-port RAM with optional write-first bypass
// One write port, one registered read port; the array itself is never reset.
module simple_dp_ram_sclk #(
   parameter int ADDR_WIDTH    = 1,
   parameter int DATA_WIDTH    = 1,
   parameter int ENABLE_BYPASS = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] raddr,
   input  logic                  re,
   output logic [DATA_WIDTH-1:0] dout
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_q;

   // No reset on the array so it maps onto block RAM; writes proceed even while rst_n is low.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q <= '0;
      end else if (re) begin
         rd_q <= mem[raddr];
      end
   end

   generate
      if (ENABLE_BYPASS != 0) begin : g_bypass
         logic [DATA_WIDTH-1:0] din_q;
         logic                  byp_q;

         // Capture and flag only move with re, so a held read keeps showing the bypassed word.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               din_q <= '0;
               byp_q <= 1'b0;
            end else if (re) begin
               din_q <= din;
               byp_q <= we && (waddr == raddr);
            end
         end

         assign dout = byp_q ? din_q : rd_q;
      end else begin : g_no_bypass
         assign dout = rd_q;
      end
   endgenerate

endmodule

// File: tb/tb_simple_dp_ram_sclk.sv
// tb/tb_simple_dp_ram_sclk.sv - directed table-driven bench for simple_dp_ram_sclk
// Two instances share stimulus: one write-first (bypass), one read-old.
module tb_simple_dp_ram_sclk;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din;
   logic [3:0] waddr;
   logic       we;
   logic [3:0] raddr;
   logic       re;
   logic [7:0] dout_b;
   logic [7:0] dout_n;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   simple_dp_ram_sclk #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ENABLE_BYPASS(1)) u_byp (
      .clk(clk), .rst_n(rst_n), .din(din), .waddr(waddr), .we(we),
      .raddr(raddr), .re(re), .dout(dout_b)
   );

   simple_dp_ram_sclk #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ENABLE_BYPASS(0)) u_nobyp (
      .clk(clk), .rst_n(rst_n), .din(din), .waddr(waddr), .we(we),
      .raddr(raddr), .re(re), .dout(dout_n)
   );

   typedef struct {
      logic       we;
      logic [3:0] wa;
      logic [7:0] d;
      logic       re;
      logic [3:0] ra;
      logic       chk;
      logic [7:0] exp_b;
      logic [7:0] exp_n;
      string      name;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic w, input logic [3:0] wa, input logic [7:0] d,
                      input logic r, input logic [3:0] ra, input logic chk,
                      input logic [7:0] eb, input logic [7:0] en, input string name);
      vec_t v;
      v.we = w; v.wa = wa; v.d = d; v.re = r; v.ra = ra;
      v.chk = chk; v.exp_b = eb; v.exp_n = en; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
   endtask

   // Drive inputs just after a falling edge, let one rising edge pass, sample on the next falling edge.
   task automatic cycle(input logic w, input logic [3:0] wa, input logic [7:0] d,
                        input logic r, input logic [3:0] ra);
      we = w; waddr = wa; din = d; re = r; raddr = ra;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; re = 1'b0; din = '0; waddr = '0; raddr = '0;

      for (int k = 0; k < 16; k++)
         add(1'b1, 4'(k), 8'(k * 3 + 1), 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, "fill");
      for (int k = 0; k < 16; k++)
         add(1'b0, 4'd0, 8'h00, 1'b1, 4'(k), 1'b1, 8'(k * 3 + 1), 8'(k * 3 + 1),
             $sformatf("read%0d", k));
      add(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b1, 8'h07, 8'h07, "hold_read");
      add(1'b1, 4'd2, 8'hFF, 1'b0, 4'd2, 1'b1, 8'h07, 8'h07, "hold_keep");
      add(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b1, 8'hFF, 8'hFF, "hold_new");
      add(1'b1, 4'd5, 8'h11, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, "coll_pre");
      add(1'b1, 4'd5, 8'h22, 1'b1, 4'd5, 1'b1, 8'h22, 8'h11, "collision");
      add(1'b1, 4'd9, 8'h5A, 1'b0, 4'd5, 1'b1, 8'h22, 8'h11, "coll_held");
      add(1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b1, 8'h22, 8'h22, "coll_after");
      add(1'b1, 4'd4, 8'h44, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, "mix_pre");
      add(1'b1, 4'd3, 8'h33, 1'b1, 4'd4, 1'b1, 8'h44, 8'h44, "mix_diff1");
      add(1'b1, 4'd6, 8'h99, 1'b1, 4'd3, 1'b1, 8'h33, 8'h33, "mix_diff2");
      add(1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 1'b1, 8'h99, 8'h99, "mix_diff3");
      add(1'b1, 4'd7, 8'hA5, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, "rst_pre_w");
      add(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 1'b1, 8'hA5, 8'hA5, "rst_pre_r");

      repeat (2) @(negedge clk);
      check("reset_byp", dout_b, 8'h00);
      check("reset_nobyp", dout_n, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         cycle(vecs[i].we, vecs[i].wa, vecs[i].d, vecs[i].re, vecs[i].ra);
         if (vecs[i].chk) begin
            check({vecs[i].name, "_byp"}, dout_b, vecs[i].exp_b);
            check({vecs[i].name, "_nobyp"}, dout_n, vecs[i].exp_n);
         end
      end

      // Asynchronous reset mid-cycle while dout shows 0xA5, released before the next rising edge.
      we = 1'b0; re = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_byp", dout_b, 8'h00);
      check("async_rst_nobyp", dout_n, 8'h00);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_hold_byp", dout_b, 8'h00);
      cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
      check("post_rst_read_byp", dout_b, 8'hA5);
      check("post_rst_read_nobyp", dout_n, 8'hA5);

      // Bypass flag must clear when a later read does not collide.
      cycle(1'b1, 4'd8, 8'hC3, 1'b1, 4'd8);
      check("coll2_byp", dout_b, 8'hC3);
      cycle(1'b1, 4'd1, 8'h3C, 1'b1, 4'd8);
      check("flag_clear_byp", dout_b, 8'hC3);
      check("flag_clear_nobyp", dout_n, 8'hC3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
